// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU: FSM state encoding and default datapath width.
package cpu4_pkg;

    localparam int CPU4_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALT    = 2'd2,
        ST_ILLEGAL = 2'd3
    } cpu4_state_e;

endpackage

// File: rtl/cpu4_pc_reg.sv
// Program-counter register with load enable and synchronous active-low reset to RESET_VECTOR.
module cpu4_pc_reg
    import cpu4_pkg::*;
#(
    parameter int                WIDTH        = CPU4_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= RESET_VECTOR;
        end else if (load_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/cpu4_pc_sequencer.sv
// PC sequencer: IDLE/RUN/HALT FSM plus next-PC mux feeding cpu4_pc_reg.
// Define CPU4_PC_CALL_RET_EN to add call/ret with a one-entry return register.
module cpu4_pc_sequencer
    import cpu4_pkg::*;
#(
    parameter int                WIDTH        = CPU4_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             stall,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             halt,
`ifdef CPU4_PC_CALL_RET_EN
    input  logic             call,
    input  logic             ret,
`endif
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             wrapped,
    output logic [1:0]       state
);

    cpu4_state_e      state_q, state_d;
    logic             wrapped_q, wrapped_d;
    logic             pc_load;
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
`ifdef CPU4_PC_CALL_RET_EN
    logic [WIDTH-1:0] ret_pc_q, ret_pc_d;
`endif

    assign pc_inc = pc_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_load   = 1'b0;
        wrapped_d = 1'b0;
`ifdef CPU4_PC_CALL_RET_EN
        ret_pc_d  = ret_pc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Priority chain: halt first, stall only matters when nothing loads.
                if (halt) begin
                    state_d = ST_HALT;
`ifdef CPU4_PC_CALL_RET_EN
                end else if (call) begin
                    ret_pc_d = pc_inc;
                    pc_d     = jump_addr;
                    pc_load  = 1'b1;
                end else if (ret) begin
                    pc_d    = ret_pc_q;
                    pc_load = 1'b1;
`endif
                end else if (jump) begin
                    pc_d    = jump_addr;
                    pc_load = 1'b1;
                end else if (!stall) begin
                    pc_d      = pc_inc;
                    pc_load   = 1'b1;
                    wrapped_d = &pc_q;
                end
            end
            ST_HALT: begin
                if (run) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = RESET_VECTOR;
                pc_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wrapped_q <= wrapped_d;
        end
    end

`ifdef CPU4_PC_CALL_RET_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_pc_q <= RESET_VECTOR;
        end else begin
            ret_pc_q <= ret_pc_d;
        end
    end
`endif

    cpu4_pc_reg #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (pc_load),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    assign pc       = pc_q;
    assign pc_valid = (state_q == ST_RUN);
    assign wrapped  = wrapped_q;
    assign state    = state_q;

endmodule

// File: tb/tb_cpu4_pc_sequencer.sv
// Directed bench for cpu4_pc_sequencer with a queue of expected outputs per clock step.
module tb_cpu4_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, run, stall, jump, halt;
    logic [3:0] jump_addr;
    logic [3:0] pc;
    logic       pc_valid, wrapped;
    logic [1:0] state;
`ifdef CPU4_PC_CALL_RET_EN
    logic       call, ret;
`endif

    int npass  = 0;
    int ntotal = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    cpu4_pc_sequencer #(.WIDTH(4), .RESET_VECTOR(4'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .stall     (stall),
        .jump      (jump),
        .jump_addr (jump_addr),
        .halt      (halt),
`ifdef CPU4_PC_CALL_RET_EN
        .call      (call),
        .ret       (ret),
`endif
        .pc        (pc),
        .pc_valid  (pc_valid),
        .wrapped   (wrapped),
        .state     (state)
    );

    task automatic check_one(input string tag, input string fld, input logic [3:0] got, input logic [3:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s.%s observed=%h expected=%h", tag, fld, got, exp);
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input logic rn, input logic r, input logic s, input logic j, input logic h,
                        input logic [3:0] a, input logic c, input logic rt,
                        input logic [3:0] e_pc, input logic e_v, input logic e_w, input logic [1:0] e_st,
                        input string tag);
        logic [7:0] e;
        string      t;
        @(negedge clk);
        rst_n = rn; run = r; stall = s; jump = j; halt = h; jump_addr = a;
`ifdef CPU4_PC_CALL_RET_EN
        call = c; ret = rt;
`else
        if (c | rt) $display("note: call/ret step without call/ret support");
`endif
        exp_q.push_back({e_pc, e_v, e_w, e_st});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_one(t, "pc",       pc,              e[7:4]);
        check_one(t, "pc_valid", {3'b0, pc_valid}, {3'b0, e[3]});
        check_one(t, "wrapped",  {3'b0, wrapped},  {3'b0, e[2]});
        check_one(t, "state",    {2'b0, state},    {2'b0, e[1:0]});
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; stall = 1'b0; jump = 1'b0; halt = 1'b0; jump_addr = 4'h0;
`ifdef CPU4_PC_CALL_RET_EN
        call = 1'b0; ret = 1'b0;
`endif
        // Reset held two cycles
        step(0,0,0,0,0, 4'h0, 0,0, 4'h0, 0, 0, 2'd0, "rst0");
        step(0,1,1,1,1, 4'h7, 0,0, 4'h0, 0, 0, 2'd0, "rst1");
        // Idle ignores stall/jump/halt
        step(1,0,1,1,1, 4'h7, 0,0, 4'h0, 0, 0, 2'd0, "idle_ign");
        // Start and free-run through the wrap
        step(1,1,0,0,0, 4'h0, 0,0, 4'h0, 1, 0, 2'd1, "run_start");
        for (int i = 1; i <= 17; i++) begin
            logic [3:0] p;
            p = 4'(i);
            step(1,0,0,0,0, 4'h0, 0,0, p, 1, (i == 16), 2'd1, $sformatf("count%0d", i));
        end
        step(1,1,0,0,0, 4'h0, 0,0, 4'h2, 1, 0, 2'd1, "run_in_run");
        step(1,0,0,0,0, 4'h0, 0,0, 4'h3, 1, 0, 2'd1, "count_to3");
        // Jump beats stall, then stall holds
        step(1,0,1,1,0, 4'hA, 0,0, 4'hA, 1, 0, 2'd1, "jump_vs_stall");
        for (int i = 0; i < 3; i++)
            step(1,0,1,0,0, 4'h0, 0,0, 4'hA, 1, 0, 2'd1, $sformatf("stall%0d", i));
        step(1,0,0,0,0, 4'h0, 0,0, 4'hB, 1, 0, 2'd1, "release");
        // Jump to 0 from all-ones never flags wrapped
        step(1,0,0,1,0, 4'hF, 0,0, 4'hF, 1, 0, 2'd1, "jump_F");
        step(1,0,0,1,0, 4'h0, 0,0, 4'h0, 1, 0, 2'd1, "jump_to0");
        // Halt beats jump; halt ignores jump/stall; resume without increment
        step(1,0,0,1,0, 4'h5, 0,0, 4'h5, 1, 0, 2'd1, "jump_5");
        step(1,0,0,1,1, 4'h9, 0,0, 4'h5, 0, 0, 2'd2, "halt");
        step(1,0,1,1,0, 4'h7, 0,0, 4'h5, 0, 0, 2'd2, "halt_ign");
        step(1,1,0,0,0, 4'h0, 0,0, 4'h5, 1, 0, 2'd1, "resume");
        step(1,0,0,0,0, 4'h0, 0,0, 4'h6, 1, 0, 2'd1, "resume_inc");
        // Halt at F must not wrap
        step(1,0,0,1,0, 4'hF, 0,0, 4'hF, 1, 0, 2'd1, "jump_F2");
        step(1,0,0,0,1, 4'h0, 0,0, 4'hF, 0, 0, 2'd2, "halt_at_F");
        step(1,1,0,0,0, 4'h0, 0,0, 4'hF, 1, 0, 2'd1, "resume_F");
        // Reset in the middle of RUN with jump asserted
        step(1,0,0,1,0, 4'h9, 0,0, 4'h9, 1, 0, 2'd1, "jump_9");
        step(0,0,0,1,0, 4'h3, 0,0, 4'h0, 0, 0, 2'd0, "rst_mid");
        step(1,0,0,0,0, 4'h0, 0,0, 4'h0, 0, 0, 2'd0, "idle_after");
`ifdef CPU4_PC_CALL_RET_EN
        step(1,1,0,0,0, 4'h0, 0,0, 4'h0, 1, 0, 2'd1, "cr_run");
        step(1,0,0,1,0, 4'h4, 0,0, 4'h4, 1, 0, 2'd1, "cr_to4");
        step(1,0,0,1,0, 4'hC, 1,0, 4'hC, 1, 0, 2'd1, "call");
        step(1,0,0,0,0, 4'h0, 0,0, 4'hD, 1, 0, 2'd1, "callee1");
        step(1,0,0,0,0, 4'h0, 0,0, 4'hE, 1, 0, 2'd1, "callee2");
        step(1,0,0,1,0, 4'h8, 0,1, 4'h5, 1, 0, 2'd1, "ret");
`endif
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
